// File: rtl/pc_unit_pkg.sv
// Shared CPU datapath package.
// Holds constants common to every register unit attached to the single
// shared datapath bus (PC, IR, MAR, MDR, general-purpose registers).
package pc_unit_pkg;

  // Width of the shared datapath bus and of every bus-attached register.
  localparam int WORD_W = 32;

endpackage : pc_unit_pkg

// File: rtl/bus_reg.sv
// Generic bus-attached register.
// Captures the shared bus on a load enable and drives its contents back
// onto the bus through a tri-state output enable.
//
// Ports:
//   clk  - system clock, rising-edge active
//   rst  - synchronous active-high reset, loads RESET_VAL
//   ld   - load enable: capture bus at the next rising clk edge
//   oe   - output enable: drive the register onto bus while high
//   bus  - shared tri-state datapath bus (inout, tri net)
module bus_reg
  import pc_unit_pkg::*;
#(
  parameter int             W         = WORD_W,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          oe,
  inout  tri   [W-1:0]  bus
);

  logic [W-1:0] q_reg;

  // Reset wins over load. Bus bits are captured as-is, including any z/x
  // left by an undriven bus; keeping the bus driven is the control
  // unit's job.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RESET_VAL;
    end else if (ld) begin
      q_reg <= bus;
    end
  end

  // Purely combinational drive so the value appears in the same delta
  // that oe rises. Independent of rst: during reset the current contents
  // are driven, which become RESET_VAL after the first reset edge.
  // With ld and oe both high the register simply reloads its own value.
  assign bus = oe ? q_reg : {W{1'bz}};

endmodule : bus_reg

// File: rtl/pc_unit.sv
// Program-counter unit for the single-bus CPU datapath.
// Holds the current instruction address, loads it from the shared bus on
// PCin and drives it back onto the bus while PCout is high. There is no
// internal increment: PC+4 is formed elsewhere and loaded through PCin.
//
// Ports:
//   clk   - system clock, rising-edge active
//   rst   - synchronous active-high reset, PC <= RESET_VAL
//   bus   - shared tri-state datapath bus (inout, tri net)
//   PCin  - load enable: capture bus into the PC at the next rising edge
//   PCout - output enable: drive the PC onto bus while high, else high-Z
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int           w         = WORD_W,
  parameter logic [w-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  inout  tri   [w-1:0]  bus,
  input  logic          PCin,
  input  logic          PCout
);

  bus_reg #(
    .W         (w),
    .RESET_VAL (RESET_VAL)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .ld  (PCin),
    .oe  (PCout),
    .bus (bus)
  );

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit. Expected bus values are queued when the
// stimulus that determines them is applied and popped when the bus is
// sampled.
module tb_pc_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         PCin;
  logic         PCout;
  logic         tb_en;
  logic [W-1:0] tb_drv;
  tri   [W-1:0] bus;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];

  // Bench-side driver onto the shared bus.
  assign bus = tb_en ? tb_drv : {W{1'bz}};

  pc_unit #(
    .w         (W),
    .RESET_VAL ('0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .PCin  (PCin),
    .PCout (PCout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input string tag, input logic [W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_bus();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h required=queued_entry", bus);
    end else begin
      e = sb.pop_front();
      assert (bus === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h required=%h", e.tag, bus, e.val);
      end
      $display("check %s: bus=%h expected=%h", e.tag, bus, e.val);
    end
  endtask

  task automatic check_known(input string tag);
    checks++;
    assert (!$isunknown(bus)) else begin
      errors++;
      $error("FAIL %s: observed=%h required=no_x_or_z", tag, bus);
    end
  endtask

  // Load a value through the bus, then read it back with PCout.
  task automatic load_and_read(input string tag, input logic [W-1:0] v);
    @(negedge clk);
    PCout  = 1'b0;
    tb_en  = 1'b1;
    tb_drv = v;
    PCin   = 1'b1;
    push_exp(tag, v);
    @(negedge clk);
    PCin  = 1'b0;
    tb_en = 1'b0;
    PCout = 1'b1;
    #1;
    check_bus();
  endtask

  logic [W-1:0] patterns [3];

  initial begin
    patterns[0] = 32'hFFFF_FFFF;
    patterns[1] = 32'h8000_0001;
    patterns[2] = 32'h1234_5677;

    rst    = 1'b1;
    PCin   = 1'b0;
    PCout  = 1'b0;
    tb_en  = 1'b0;
    tb_drv = '0;

    // 1. Reset for two cycles, then read out over an otherwise idle bus.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    PCout = 1'b1;
    push_exp("reset_value", 32'h0000_0000);
    #1;
    check_bus();

    // 2. Load 0x0000000F.
    load_and_read("load", 32'h0000_000F);

    // 3. Hold: bench drives 0 with PCin low; block must not be driving.
    @(negedge clk);
    PCout  = 1'b0;
    tb_en  = 1'b1;
    tb_drv = 32'h0000_0000;
    push_exp("no_drive_low", 32'h0000_0000);
    #1;
    check_bus();
    @(negedge clk);
    tb_en = 1'b0;
    PCout = 1'b1;
    push_exp("hold", 32'h0000_000F);
    #1;
    check_bus();

    // 4. Read-out is combinational; release is immediate.
    @(negedge clk);
    PCout = 1'b0;
    #1;
    PCout = 1'b1;
    push_exp("readout_same_cycle", 32'h0000_000F);
    #0;
    #0;
    check_bus();
    PCout  = 1'b0;
    tb_en  = 1'b1;
    tb_drv = 32'hFFFF_FFF0;
    push_exp("release_same_cycle", 32'hFFFF_FFF0);
    #1;
    check_bus();

    // 5. Reset has priority over a simultaneous load.
    @(negedge clk);
    rst    = 1'b1;
    PCin   = 1'b1;
    tb_drv = 32'hDEAD_BEEF;
    @(negedge clk);
    rst   = 1'b0;
    PCin  = 1'b0;
    tb_en = 1'b0;
    PCout = 1'b1;
    push_exp("reset_priority", 32'h0000_0000);
    #1;
    check_bus();

    // 6. Simultaneous PCin and PCout with nothing else on the bus.
    load_and_read("load_0x40", 32'h0000_0040);
    @(negedge clk);
    PCin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp($sformatf("simul_pre_%0d", i), 32'h0000_0040);
      #1;
      check_bus();
      check_known($sformatf("simul_known_%0d", i));
      @(posedge clk);
      push_exp($sformatf("simul_post_%0d", i), 32'h0000_0040);
      #1;
      check_bus();
      @(negedge clk);
    end
    PCin = 1'b0;
    push_exp("after_simul", 32'h0000_0040);
    #1;
    check_bus();

    // Full-width values are loaded without masking or alignment.
    for (int i = 0; i < 3; i++) begin
      load_and_read($sformatf("pattern_%0d", i), patterns[i]);
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_unit
